// File: rtl/sobel5_window_filter.sv
// sobel5_window_filter: 5x5 Sobel gradient magnitude over a 200-bit pixel window.
// Four-stage pipeline (row/column partial sums, Gx/Gy, magnitude, scale/threshold/mask)
// with the sync and coordinate signals delayed alongside so they stay aligned with edge_pixel.
module sobel5_window_filter #(
   parameter int ACTIVE_W = 640,
   parameter int ACTIVE_H = 480,
   parameter int H_MASK   = 4,
   parameter int V_MASK   = 4,
   parameter int SHIFT    = 6
) (
   input  logic         clock,
   input  logic         reset,
   input  logic [10:0]  hcount,
   input  logic [9:0]   vcount,
   input  logic         hsync,
   input  logic         vsync,
   input  logic         blank,
   input  logic [199:0] matrix,
   input  logic [7:0]   threshold,
   output logic [7:0]   edge_pixel,
   output logic [10:0]  hcount_out,
   output logic [9:0]   vcount_out,
   output logic         hsync_out,
   output logic         vsync_out,
   output logic         blank_out,
   output logic         out_valid
);

   localparam logic [10:0] ACTIVE_W_C = 11'(ACTIVE_W);
   localparam logic [9:0]  ACTIVE_H_C = 10'(ACTIVE_H);
   localparam logic [10:0] H_MASK_C   = 11'(H_MASK);
   localparam logic [9:0]  V_MASK_C   = 10'(V_MASK);

   // Pixel at row r (0 = top) and column c (0 = left) of the window.
   function automatic logic [7:0] pix(input logic [199:0] m, input int r, input int c);
      return m[8*(5*r + 4 - c) +: 8];
   endfunction

   // Zero-extend a pixel into the signed partial-sum width.
   function automatic logic signed [11:0] zx(input logic [7:0] p);
      return $signed({4'd0, p});
   endfunction

   // Derivative kernel (-1,-2,0,2,1) applied to five pixels in order 0..4.
   function automatic logic signed [11:0] diff5(input logic [7:0] p0, input logic [7:0] p1,
                                                input logic [7:0] p2, input logic [7:0] p3,
                                                input logic [7:0] p4);
      return zx(p4) + (zx(p3) <<< 1) - (zx(p1) <<< 1) - zx(p0);
   endfunction

   // Sign-extend a partial sum to the gradient width.
   function automatic logic signed [15:0] sx(input logic signed [11:0] a);
      return $signed({{4{a[11]}}, a});
   endfunction

   // Smoothing kernel (1,4,6,4,1) applied to five partial sums.
   function automatic logic signed [15:0] smooth5(input logic signed [11:0] a0, input logic signed [11:0] a1,
                                                  input logic signed [11:0] a2, input logic signed [11:0] a3,
                                                  input logic signed [11:0] a4);
      return sx(a0) + (sx(a1) <<< 2) + (sx(a2) <<< 2) + (sx(a2) <<< 1) + (sx(a3) <<< 2) + sx(a4);
   endfunction

   // Absolute value; |G| never exceeds 12240 so 15 bits suffice.
   function automatic logic [14:0] abs16(input logic signed [15:0] g);
      logic signed [15:0] t;
      t = g[15] ? -g : g;
      return t[14:0];
   endfunction

   logic signed [11:0] hx_s [5];
   logic signed [11:0] vy_s [5];
   logic signed [11:0] hx_r [5];
   logic signed [11:0] vy_r [5];
   logic signed [15:0] gx_r;
   logic signed [15:0] gy_r;
   logic [14:0]        mag_r;
   logic [14:0]        shifted_s;
   logic [7:0]         scaled_s;
   logic [7:0]         edge_s;
   logic               mask_s;
   logic               mask_r [3];
   logic [10:0]        hcount_d_r [4];
   logic [9:0]         vcount_d_r [4];
   logic               hsync_d_r [4];
   logic               vsync_d_r [4];
   logic               blank_d_r [4];
   logic [2:0]         fill_r;
   logic [7:0]         edge_r;
   logic               valid_r;

   // Stage 0: per-row horizontal derivatives, per-column vertical derivatives, and the mask.
   always_comb begin
      for (int r = 0; r < 5; r++) begin
         hx_s[r] = diff5(pix(matrix, r, 0), pix(matrix, r, 1), pix(matrix, r, 2),
                         pix(matrix, r, 3), pix(matrix, r, 4));
      end
      for (int c = 0; c < 5; c++) begin
         vy_s[c] = diff5(pix(matrix, 0, c), pix(matrix, 1, c), pix(matrix, 2, c),
                         pix(matrix, 3, c), pix(matrix, 4, c));
      end
      mask_s = blank | (hcount < H_MASK_C) | (vcount < V_MASK_C) |
               (hcount >= ACTIVE_W_C) | (vcount >= ACTIVE_H_C);
   end

   // Stage 4 combinational: scale, saturate, threshold and apply the carried mask.
   always_comb begin
      shifted_s = mag_r >> SHIFT;
      if (shifted_s > 15'd255) begin
         scaled_s = 8'd255;
      end else begin
         scaled_s = shifted_s[7:0];
      end
      if (mask_r[2]) begin
         edge_s = 8'd0;
      end else if (threshold == 8'd0) begin
         edge_s = scaled_s;
      end else if (scaled_s >= threshold) begin
         edge_s = 8'd255;
      end else begin
         edge_s = 8'd0;
      end
   end

   // Arithmetic pipeline registers S1..S4 plus the mask carried alongside them.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < 5; i++) begin
            hx_r[i] <= 12'sd0;
            vy_r[i] <= 12'sd0;
         end
         for (int i = 0; i < 3; i++) begin
            mask_r[i] <= 1'b1;
         end
         gx_r   <= 16'sd0;
         gy_r   <= 16'sd0;
         mag_r  <= 15'd0;
         edge_r <= 8'd0;
      end else begin
         hx_r      <= hx_s;
         vy_r      <= vy_s;
         mask_r[0] <= mask_s;
         mask_r[1] <= mask_r[0];
         mask_r[2] <= mask_r[1];
         gx_r      <= smooth5(hx_r[0], hx_r[1], hx_r[2], hx_r[3], hx_r[4]);
         gy_r      <= smooth5(vy_r[0], vy_r[1], vy_r[2], vy_r[3], vy_r[4]);
         mag_r     <= abs16(gx_r) + abs16(gy_r);
         edge_r    <= edge_s;
      end
   end

   // Four-deep delay line for coordinates and syncs, matching the arithmetic latency.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) begin
            hcount_d_r[i] <= 11'd0;
            vcount_d_r[i] <= 10'd0;
            hsync_d_r[i]  <= 1'b1;
            vsync_d_r[i]  <= 1'b1;
            blank_d_r[i]  <= 1'b1;
         end
      end else begin
         hcount_d_r[0] <= hcount;
         vcount_d_r[0] <= vcount;
         hsync_d_r[0]  <= hsync;
         vsync_d_r[0]  <= vsync;
         blank_d_r[0]  <= blank;
         for (int i = 1; i < 4; i++) begin
            hcount_d_r[i] <= hcount_d_r[i-1];
            vcount_d_r[i] <= vcount_d_r[i-1];
            hsync_d_r[i]  <= hsync_d_r[i-1];
            vsync_d_r[i]  <= vsync_d_r[i-1];
            blank_d_r[i]  <= blank_d_r[i-1];
         end
      end
   end

   // Fill counter and valid flag: valid only once the pipe holds post-reset data.
   always_ff @(posedge clock) begin
      if (reset) begin
         fill_r  <= 3'd0;
         valid_r <= 1'b0;
      end else begin
         if (fill_r != 3'd4) begin
            fill_r <= fill_r + 3'd1;
         end else begin
            fill_r <= fill_r;
         end
         // fill_r reaches 4 on this same edge when it currently reads 3 or more.
         valid_r <= (fill_r >= 3'd3) & ~blank_d_r[2] & ~mask_r[2];
      end
   end

   assign edge_pixel = edge_r;
   assign out_valid  = valid_r;
   assign hcount_out = hcount_d_r[3];
   assign vcount_out = vcount_d_r[3];
   assign hsync_out  = hsync_d_r[3];
   assign vsync_out  = vsync_d_r[3];
   assign blank_out  = blank_d_r[3];

endmodule

// File: tb/tb_sobel5_window_filter.sv
// tb_sobel5_window_filter: table vectors, latency sequence and a random stream with a
// mid-frame reset, checked against a direct 25-tap reference model through a scoreboard.
module tb_sobel5_window_filter;

   logic         clock = 1'b0;
   logic         reset;
   logic [10:0]  hcount;
   logic [9:0]   vcount;
   logic         hsync, vsync, blank;
   logic [199:0] matrix;
   logic [7:0]   thr;
   logic [7:0]   edge_pixel, edge5;
   logic [10:0]  hcount_out, hc5;
   logic [9:0]   vcount_out, vc5;
   logic         hsync_out, vsync_out, blank_out, out_valid;
   logic         hs5, vs5, bl5, ov5;

   always #5 clock = ~clock;

   sobel5_window_filter dut (
      .clock(clock), .reset(reset), .hcount(hcount), .vcount(vcount), .hsync(hsync),
      .vsync(vsync), .blank(blank), .matrix(matrix), .threshold(thr),
      .edge_pixel(edge_pixel), .hcount_out(hcount_out), .vcount_out(vcount_out),
      .hsync_out(hsync_out), .vsync_out(vsync_out), .blank_out(blank_out), .out_valid(out_valid)
   );

   sobel5_window_filter #(.SHIFT(5)) dut5 (
      .clock(clock), .reset(reset), .hcount(hcount), .vcount(vcount), .hsync(hsync),
      .vsync(vsync), .blank(blank), .matrix(matrix), .threshold(thr),
      .edge_pixel(edge5), .hcount_out(hc5), .vcount_out(vc5),
      .hsync_out(hs5), .vsync_out(vs5), .blank_out(bl5), .out_valid(ov5)
   );

   typedef struct {
      logic [199:0] m;
      logic [10:0]  hc;
      logic [9:0]   vc;
      logic         bl;
      logic [7:0]   th;
      int           e6;
      int           e5;
      int           ev;
   } vec_t;

   typedef struct {
      int          s6;
      int          s5;
      logic        msk;
      logic [10:0] hc;
      logic [9:0]  vc;
      logic        hs;
      logic        vs;
      logic        bl;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[14];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   // Reference: direct 25-tap sum with signed integer weights.
   function automatic int ref_scaled(input logic [199:0] m, input int sh);
      int v[5];
      int d[5];
      int gx, gy, z, r, c, mag, s;
      v = '{1, 4, 6, 4, 1};
      d = '{-1, -2, 0, 2, 1};
      gx = 0;
      gy = 0;
      for (int k = 0; k < 25; k++) begin
         z = int'(m[8*k +: 8]);
         r = k / 5;
         c = 4 - (k % 5);
         gx += v[r] * d[c] * z;
         gy += d[r] * v[c] * z;
      end
      mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
      s = mag >> sh;
      return (s > 255) ? 255 : s;
   endfunction

   function automatic logic ref_mask(input logic [10:0] hc, input logic [9:0] vc, input logic bl);
      return bl || (int'(hc) < 4) || (int'(vc) < 4) || (int'(hc) >= 640) || (int'(vc) >= 480);
   endfunction

   function automatic int exp_edge(input int s, input logic msk, input logic [7:0] th);
      if (msk) return 0;
      if (th == 8'd0) return s;
      return (s >= int'(th)) ? 255 : 0;
   endfunction

   function automatic logic [199:0] mat_fill(input logic [7:0] val);
      logic [199:0] m;
      for (int k = 0; k < 25; k++) m[8*k +: 8] = val;
      return m;
   endfunction

   // Columns 3 and 4 (right side) bright.
   function automatic logic [199:0] mat_cols();
      logic [199:0] m;
      for (int k = 0; k < 25; k++) m[8*k +: 8] = ((4 - (k % 5)) >= 3) ? 8'hFF : 8'h00;
      return m;
   endfunction

   // Rows 3 and 4 (bottom) bright.
   function automatic logic [199:0] mat_rows();
      logic [199:0] m;
      for (int k = 0; k < 25; k++) m[8*k +: 8] = ((k / 5) >= 3) ? 8'hFF : 8'h00;
      return m;
   endfunction

   function automatic vec_t mkv(input logic [199:0] m, input int hc, input int vc, input logic bl,
                                input int th, input int e6, input int e5, input int ev);
      vec_t x;
      x.m = m; x.hc = 11'(hc); x.vc = 10'(vc); x.bl = bl; x.th = 8'(th);
      x.e6 = e6; x.e5 = e5; x.ev = ev;
      return x;
   endfunction

   // One clock: record expectation of current inputs, then check the output now due.
   task automatic tick();
      exp_t e;
      e.s6  = ref_scaled(matrix, 6);
      e.s5  = ref_scaled(matrix, 5);
      e.msk = ref_mask(hcount, vcount, blank);
      e.hc  = hcount;
      e.vc  = vcount;
      e.hs  = hsync;
      e.vs  = vsync;
      e.bl  = blank;
      sb.push_back(e);
      @(posedge clock);
      @(negedge clock);
      if (sb.size() == 4) begin
         e = sb.pop_front();
         chk("edge", int'(edge_pixel), exp_edge(e.s6, e.msk, thr));
         chk("edge_shift5", int'(edge5), exp_edge(e.s5, e.msk, thr));
         chk("out_valid", int'(out_valid), int'(!e.msk));
         chk("hcount_out", int'(hcount_out), int'(e.hc));
         chk("vcount_out", int'(vcount_out), int'(e.vc));
         chk("hsync_out", int'(hsync_out), int'(e.hs));
         chk("vsync_out", int'(vsync_out), int'(e.vs));
         chk("blank_out", int'(blank_out), int'(e.bl));
      end else begin
         chk("fill_valid", int'(out_valid), 0);
         chk("fill_edge", int'(edge_pixel), 0);
      end
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         @(negedge clock);
         chk("rst_edge", int'(edge_pixel), 0);
         chk("rst_hcount", int'(hcount_out), 0);
         chk("rst_vcount", int'(vcount_out), 0);
         chk("rst_hsync", int'(hsync_out), 1);
         chk("rst_vsync", int'(vsync_out), 1);
         chk("rst_blank", int'(blank_out), 1);
         chk("rst_valid", int'(out_valid), 0);
      end
      reset = 1'b0;
      sb.delete();
   endtask

   initial begin
      reset  = 1'b1;
      hcount = 11'd100;
      vcount = 10'd100;
      hsync  = 1'b1;
      vsync  = 1'b1;
      blank  = 1'b0;
      thr    = 8'd0;
      matrix = mat_fill(8'h80);

      vecs[0]  = mkv(mat_fill(8'h80), 100, 100, 1'b0, 0,   0,   0,   1);
      vecs[1]  = mkv(mat_cols(),      100, 100, 1'b0, 0,   191, 255, 1);
      vecs[2]  = mkv(mat_cols(),      100, 100, 1'b0, 191, 255, 255, 1);
      vecs[3]  = mkv(mat_cols(),      100, 100, 1'b0, 192, 0,   255, 1);
      vecs[4]  = mkv(mat_rows(),      100, 100, 1'b0, 0,   191, 255, 1);
      vecs[5]  = mkv(mat_rows(),      100, 100, 1'b0, 191, 255, 255, 1);
      vecs[6]  = mkv(mat_rows(),      100, 100, 1'b0, 192, 0,   255, 1);
      vecs[7]  = mkv(mat_cols(),      2,   100, 1'b0, 0,   0,   0,   0);
      vecs[8]  = mkv(mat_cols(),      100, 100, 1'b1, 0,   0,   0,   0);
      vecs[9]  = mkv(mat_cols(),      100, 480, 1'b0, 0,   0,   0,   0);
      vecs[10] = mkv(mat_cols(),      640, 100, 1'b0, 0,   0,   0,   0);
      vecs[11] = mkv(mat_cols(),      100, 3,   1'b0, 0,   0,   0,   0);
      vecs[12] = mkv(mat_cols(),      4,   4,   1'b0, 0,   191, 255, 1);
      vecs[13] = mkv(mat_cols(),      639, 479, 1'b0, 0,   191, 255, 1);

      @(negedge clock);
      do_reset(3);

      // Table: hold each vector until it has crossed the whole pipe.
      for (int i = 0; i < 14; i++) begin
         matrix = vecs[i].m;
         hcount = vecs[i].hc;
         vcount = vecs[i].vc;
         blank  = vecs[i].bl;
         thr    = vecs[i].th;
         repeat (4) tick();
         chk($sformatf("tbl%0d_edge", i), int'(edge_pixel), vecs[i].e6);
         chk($sformatf("tbl%0d_edge_shift5", i), int'(edge5), vecs[i].e5);
         chk($sformatf("tbl%0d_valid", i), int'(out_valid), vecs[i].ev);
      end

      // Single-cycle step: result must appear on exactly the fourth clock.
      hcount = 11'd100;
      vcount = 10'd100;
      blank  = 1'b0;
      thr    = 8'd0;
      matrix = mat_fill(8'h00);
      repeat (4) tick();
      matrix = mat_cols();
      tick();
      chk("lat_c1", int'(edge_pixel), 0);
      matrix = mat_fill(8'h00);
      tick();
      chk("lat_c2", int'(edge_pixel), 0);
      tick();
      chk("lat_c3", int'(edge_pixel), 0);
      tick();
      chk("lat_c4", int'(edge_pixel), 191);
      tick();
      chk("lat_c5", int'(edge_pixel), 0);

      // Random stream with a reset in the middle of the frame.
      for (int t = 0; t < 300; t++) begin
         if (t == 150) do_reset(2);
         for (int k = 0; k < 25; k++) matrix[8*k +: 8] = 8'($urandom_range(0, 255));
         hcount = 11'($urandom_range(0, 700));
         vcount = 10'($urandom_range(0, 500));
         blank  = ($urandom_range(0, 7) == 0);
         hsync  = 1'($urandom_range(0, 1));
         vsync  = 1'($urandom_range(0, 1));
         if ((t % 37) == 0) thr = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(1, 255)) : 8'd0;
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
